// File: rtl/eth_crc32_stream_if.sv
// Stream bundle for the Ethernet FCS engine: framed beats in, FCS beats out,
// plus the end-of-frame result.
interface eth_crc32_stream_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_first;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  result_valid;
  logic [31:0]           crc_value;
  logic                  crc_ok;

  // Upstream side: supplies frame beats and accepts FCS beats.
  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, result_valid, crc_value, crc_ok
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, result_valid, crc_value, crc_ok
  );
endinterface

// File: rtl/eth_crc32_stream.sv
// Ethernet FCS engine: running reflected CRC-32 over a 4- or 8-bit framed
// stream, end-of-frame FCS/residue report and optional FCS serialisation.
module eth_crc32_stream #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter bit          APPEND_FCS = 1'b1,
  parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
  input  logic                 clk,
  input  logic                 reset,
  eth_crc32_stream_if.slave    bus
);

  localparam int unsigned NBEATS = 32 / DATA_WIDTH;
  localparam int unsigned KW     = $clog2(NBEATS);
  localparam logic [31:0] POLY   = 32'hEDB88320;
  localparam logic [31:0] INIT   = 32'hFFFFFFFF;

  // Only MII nibbles and GMII bytes are meaningful beat widths.
  if (!(DATA_WIDTH == 4 || DATA_WIDTH == 8)) begin : g_bad_width
    $error("eth_crc32_stream: DATA_WIDTH must be 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    EMIT   = 2'd3
  } state_t;

  // One reflected CRC step over a beat, bit 0 first on the wire.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic [DATA_WIDTH-1:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[31:1]} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  state_t                state, state_next;
  logic [31:0]           crc_reg, crc_next;
  logic [KW-1:0]         k, k_next;
  logic                  in_ready_r, in_ready_next;
  logic                  out_valid_r, out_valid_next;
  logic [DATA_WIDTH-1:0] out_data_r, out_data_next;
  logic                  out_last_r, out_last_next;
  logic                  result_valid_r, result_valid_next;
  logic [31:0]           crc_value_r, crc_value_next;
  logic                  crc_ok_r, crc_ok_next;

  logic                  beat;
  logic                  frame_end;
  logic [31:0]           step_init;
  logic [31:0]           step_run;

  assign beat      = bus.in_valid & in_ready_r;
  assign step_init = crc_step(INIT, bus.in_data);
  assign step_run  = crc_step(crc_reg, bus.in_data);

  // Next-state and next-output logic; all outputs are registered copies.
  always_comb begin
    state_next        = state;
    crc_next          = crc_reg;
    k_next            = k;
    in_ready_next     = in_ready_r;
    out_valid_next    = out_valid_r;
    out_data_next     = out_data_r;
    out_last_next     = out_last_r;
    result_valid_next = 1'b0;
    crc_value_next    = crc_value_r;
    crc_ok_next       = crc_ok_r;
    frame_end         = 1'b0;

    case (state)
      IDLE: begin
        if (beat && bus.in_first) begin
          crc_next  = step_init;
          frame_end = bus.in_last;
          if (!bus.in_last) state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          // A fresh in_first silently abandons the frame in progress.
          crc_next  = bus.in_first ? step_init : step_run;
          frame_end = bus.in_last;
        end
      end
      FINISH: begin
        if (APPEND_FCS) begin
          state_next     = EMIT;
          out_valid_next = 1'b1;
          out_data_next  = crc_value_r[DATA_WIDTH-1:0];
          out_last_next  = 1'b0;
          k_next         = '0;
        end else begin
          state_next    = IDLE;
          in_ready_next = 1'b1;
        end
      end
      EMIT: begin
        if (out_valid_r && bus.out_ready) begin
          if (out_last_r) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            out_data_next  = '0;
            k_next         = '0;
            in_ready_next  = 1'b1;
          end else begin
            k_next        = k + KW'(1);
            out_data_next = DATA_WIDTH'(crc_value_r >> (32'(k_next) * DATA_WIDTH));
            out_last_next = (k_next == KW'(NBEATS - 1));
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The result is reported from the register value the last beat produces.
    if (frame_end) begin
      state_next        = FINISH;
      in_ready_next     = 1'b0;
      result_valid_next = 1'b1;
      crc_value_next    = ~crc_next;
      crc_ok_next       = (crc_next == RESIDUE);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      crc_reg        <= INIT;
      k              <= '0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      out_last_r     <= 1'b0;
      result_valid_r <= 1'b0;
      crc_value_r    <= 32'h0;
      crc_ok_r       <= 1'b0;
    end else begin
      state          <= state_next;
      crc_reg        <= crc_next;
      k              <= k_next;
      in_ready_r     <= in_ready_next;
      out_valid_r    <= out_valid_next;
      out_data_r     <= out_data_next;
      out_last_r     <= out_last_next;
      result_valid_r <= result_valid_next;
      crc_value_r    <= crc_value_next;
      crc_ok_r       <= crc_ok_next;
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_last     = out_last_r;
  assign bus.result_valid = result_valid_r;
  assign bus.crc_value    = crc_value_r;
  assign bus.crc_ok       = crc_ok_r;

endmodule
